// File: rtl/ysyx_25050147_lsu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25050147_lsu_pkg
// Shared definitions for the load/store unit:
//   - state_t      : LSU sequencing FSM states
//   - funct3 codes : RISC-V load/store funct3 encodings
//   - size_bytes() : access size in bytes from funct3[1:0]
// ----------------------------------------------------------------------------
package ysyx_25050147_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Load funct3
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Store funct3
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // 00 -> 1, 01 -> 2, 10 -> 4, 11 -> 8 bytes
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/ysyx_25050147_lsu_align.sv
// ----------------------------------------------------------------------------
// ysyx_25050147_lsu_align
// Combinational byte-lane datapath for the LSU.
//   op        : funct3 of the access (size in [1:0], zero-extend in [2])
//   off       : byte offset of the access inside one bus beat
//   wdata     : right-justified store data
//   mask0/1   : byte enables for beat 0 / beat 1 (beat 1 is zero if no split)
//   wdata0/1  : lane-shifted store data for beat 0 / beat 1
//   rdata_lo  : read data of beat 0
//   rdata_hi  : read data of beat 1 (zero for single-beat loads)
//   rdata_ext : merged, truncated and sign/zero-extended load result
// ----------------------------------------------------------------------------
module ysyx_25050147_lsu_align
    import ysyx_25050147_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]               op,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN/8-1:0]        mask0,
    output logic [XLEN/8-1:0]        mask1,
    output logic [XLEN-1:0]          wdata0,
    output logic [XLEN-1:0]          wdata1,
    input  logic [XLEN-1:0]          rdata_lo,
    input  logic [XLEN-1:0]          rdata_hi,
    output logic [XLEN-1:0]          rdata_ext
);

    localparam int NB = XLEN / 8;
    localparam logic [2*NB-1:0] MASK_ONE = 1;

    logic [3:0]          nbytes;
    logic [2*NB-1:0]     mask_wide;
    logic [2*XLEN-1:0]   wdata_wide;
    logic [XLEN-1:0]     merged;
    logic [XLEN-1:0]     left_just;
    int                  shamt;

    // Both beats come from one double-width shift: the low half is beat 0,
    // the bits shifted past the beat boundary form beat 1.
    // NOTE: every always_comb output gets a value on every path (defaults
    // first where branches exist) so no latch is inferred.
    always_comb begin
        nbytes     = size_bytes(op[1:0]);
        mask_wide  = ((MASK_ONE << nbytes) - MASK_ONE) << off;
        mask0      = mask_wide[NB-1:0];
        mask1      = mask_wide[2*NB-1:NB];

        wdata_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        wdata0     = wdata_wide[XLEN-1:0];
        wdata1     = wdata_wide[2*XLEN-1:XLEN];

        // Bring the addressed bytes down to bit 0 across both beats.
        merged     = XLEN'({rdata_hi, rdata_lo} >> {off, 3'b000});

        // Left-justify the valid bytes, then shift back logically or
        // arithmetically to zero- or sign-extend.
        shamt      = XLEN - 8 * int'(nbytes);
        if (shamt < 0) shamt = 0;
        left_just  = merged << shamt;
        rdata_ext  = left_just >> shamt;
        if (!op[2]) rdata_ext = $signed(left_just) >>> shamt;
    end

endmodule

// File: rtl/ysyx_25050147_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_25050147_lsu
// Load/store unit between EXU and the data-memory bus. Accepts one request at
// a time, issues one or two aligned bus beats, returns the extended load data
// (or an error) on a held response handshake.
//   req_*      : request from EXU (valid/ready), captured at acceptance
//   rsp_*      : response to consumer (valid/ready), held until accepted
//   mem_req_*  : registered bus beat request, stable under backpressure
//   mem_rsp_*  : bus read data / write ack, always accepted in WAIT states
// Parameters: XLEN (32/64), AW, SPLIT_MISALIGNED (1 split, 0 error).
// ----------------------------------------------------------------------------
module ysyx_25050147_lsu
    import ysyx_25050147_lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int AW               = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_op,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    state_t            state;

    // Captured request
    logic [2:0]        op_q;
    logic              wen_q;
    logic [AW-1:0]     base_q;
    logic [OW-1:0]     off_q;
    logic [XLEN-1:0]   wdata_q;
    logic              split_q;
    logic [XLEN-1:0]   d0_q;

    // Request decode
    logic [OW-1:0]     req_off;
    logic [AW-1:0]     req_base;
    logic [3:0]        req_nbytes;
    logic              req_cross;
    logic              req_legal;
    logic              req_bad;

    // Aligner interface
    logic [2:0]        a_op;
    logic [OW-1:0]     a_off;
    logic [XLEN-1:0]   a_wdata;
    logic [XLEN-1:0]   a_lo;
    logic [XLEN-1:0]   a_hi;
    logic [NB-1:0]     mask0;
    logic [NB-1:0]     mask1;
    logic [XLEN-1:0]   wdata0;
    logic [XLEN-1:0]   wdata1;
    logic [XLEN-1:0]   rdata_ext;

    assign req_ready = (state == IDLE);

    always_comb begin
        req_off    = req_addr[OW-1:0];
        req_base   = {req_addr[AW-1:OW], {OW{1'b0}}};
        req_nbytes = size_bytes(req_op[1:0]);
        req_cross  = (5'(req_off) + 5'(req_nbytes)) > 5'(NB);

        req_legal = 1'b0;
        if (req_wen) begin
            req_legal = (req_op == SB) || (req_op == SH) || (req_op == SW) ||
                        ((XLEN == 64) && (req_op == SD));
        end else begin
            req_legal = (req_op == LB)  || (req_op == LH)  || (req_op == LW) ||
                        (req_op == LBU) || (req_op == LHU) ||
                        ((XLEN == 64) && ((req_op == LD) || (req_op == LWU)));
        end
        req_bad = !req_legal || (req_cross && !SPLIT_MISALIGNED);
    end

    // In IDLE the aligner works on the live request so beat 0 can be
    // registered at acceptance; afterwards it works on the captured copy.
    always_comb begin
        a_op    = (state == IDLE) ? req_op    : op_q;
        a_off   = (state == IDLE) ? req_off   : off_q;
        a_wdata = (state == IDLE) ? req_wdata : wdata_q;
        a_lo    = (state == WAIT1) ? d0_q      : mem_rdata;
        a_hi    = (state == WAIT1) ? mem_rdata : '0;
    end

    ysyx_25050147_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .op        (a_op),
        .off       (a_off),
        .wdata     (a_wdata),
        .mask0     (mask0),
        .mask1     (mask1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .rdata_lo  (a_lo),
        .rdata_hi  (a_hi),
        .rdata_ext (rdata_ext)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= '0;
            wen_q         <= 1'b0;
            base_q        <= '0;
            off_q         <= '0;
            wdata_q       <= '0;
            split_q       <= 1'b0;
            d0_q          <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        wen_q   <= req_wen;
                        base_q  <= req_base;
                        off_q   <= req_off;
                        wdata_q <= req_wdata;
                        split_q <= req_cross;
                        if (req_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_addr      <= req_base;
                            mem_wen       <= req_wen;
                            mem_wdata     <= wdata0;
                            mem_wmask     <= mask0;
                            state         <= REQ0;
                        end
                    end
                end

                REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT0;
                    end
                end

                WAIT0: begin
                    if (mem_rsp_valid) begin
                        if (split_q) begin
                            d0_q          <= mem_rdata;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= base_q + AW'(NB);
                            mem_wen       <= wen_q;
                            mem_wdata     <= wdata1;
                            mem_wmask     <= mask1;
                            state         <= REQ1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= wen_q ? '0 : rdata_ext;
                            state     <= RESP;
                        end
                    end
                end

                REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT1;
                    end
                end

                WAIT1: begin
                    if (mem_rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wen_q ? '0 : rdata_ext;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25050147_lsu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25050147_lsu
// Directed bench for the LSU at XLEN = 32. dut splits crossing accesses,
// dut_ns (SPLIT_MISALIGNED = 0) rejects them. Inputs are driven and outputs
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ysyx_25050147_lsu;

    logic        clk;
    logic        rst_n;

    logic        req_valid;
    logic        req_valid_ns;
    logic        req_wen;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        rsp_ready_ns;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic        req_ready,      req_ready_ns;
    logic        rsp_valid,      rsp_valid_ns;
    logic [31:0] rsp_rdata,      rsp_rdata_ns;
    logic        rsp_err,        rsp_err_ns;
    logic        mem_req_valid,  mem_req_valid_ns;
    logic [31:0] mem_addr,       mem_addr_ns;
    logic        mem_wen,        mem_wen_ns;
    logic [31:0] mem_wdata,      mem_wdata_ns;
    logic [3:0]  mem_wmask,      mem_wmask_ns;

    int checks;
    int failures;

    ysyx_25050147_lsu #(.XLEN(32), .AW(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_wen (req_wen),
        .req_op (req_op), .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
        .mem_addr (mem_addr), .mem_wen (mem_wen), .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask), .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata (mem_rdata)
    );

    ysyx_25050147_lsu #(.XLEN(32), .AW(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid_ns), .req_ready (req_ready_ns), .req_wen (req_wen),
        .req_op (req_op), .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_ns), .rsp_ready (rsp_ready_ns),
        .rsp_rdata (rsp_rdata_ns), .rsp_err (rsp_err_ns),
        .mem_req_valid (mem_req_valid_ns), .mem_req_ready (mem_req_ready),
        .mem_addr (mem_addr_ns), .mem_wen (mem_wen_ns), .mem_wdata (mem_wdata_ns),
        .mem_wmask (mem_wmask_ns), .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no comparisons) ----------------

    // Present a request for one cycle, then scramble the request inputs.
    task automatic issue(input logic wen, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_wen   = wen;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_op    = 3'b111;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
    endtask

    // Wait (bounded) for a beat, record it, accept it, return read data.
    task automatic serve_beat(input logic [31:0] rd,
                              output logic [31:0] a, output logic [3:0] m,
                              output logic [31:0] wd, output logic we,
                              output logic got);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        a  = mem_addr;
        m  = mem_wmask;
        wd = mem_wdata;
        we = mem_wen;
        if (!got) return;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0BAD_F00D;
    endtask

    // Wait (bounded) for a response, record it, accept it.
    task automatic take_rsp(output logic [31:0] rd, output logic err,
                            output logic got);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rd  = rsp_rdata;
        err = rsp_err;
        if (!got) return;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_req_valid, mem_wen} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got={rdy,rv,err,mv,wen}=%b expected 10000",
                     {req_ready, rsp_valid, rsp_err, mem_req_valid, mem_wen});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_wdata, mem_wmask} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h mask=%h expected all 0",
                     rsp_rdata, mem_addr, mem_wdata, mem_wmask);
        end
    endtask

    task automatic test_store_word();
        logic [31:0] a, wd, rd;
        logic [3:0]  m;
        logic        we, got, err;
        issue(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF);
        checks++;
        if (mem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL sw_beat_latency mem_req_valid=%b expected 1 at cycle 1", mem_req_valid);
        end
        serve_beat(32'h0, a, m, wd, we, got);
        checks++;
        if ({got, a, m, wd, we} !== {1'b1, 32'h8000_0004, 4'hF, 32'hDEAD_BEEF, 1'b1}) begin
            failures++;
            $display("FAIL sw_beat got=%b addr=%h mask=%h wdata=%h wen=%b expected 1 80000004 f deadbeef 1",
                     got, a, m, wd, we);
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL sw_rsp_latency rsp_valid=%b expected 1 at cycle 3", rsp_valid);
        end
        take_rsp(rd, err, got);
        checks++;
        if ({got, err, rd} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL sw_rsp got=%b err=%b rdata=%h expected 1 0 00000000", got, err, rd);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL sw_ready_after req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_store_byte();
        logic [31:0] a, wd, rd;
        logic [3:0]  m;
        logic        we, got, err;
        issue(1'b1, 3'b000, 32'h8000_0003, 32'h1234_5678);
        serve_beat(32'h0, a, m, wd, we, got);
        checks++;
        if ({got, a, m, wd, we} !== {1'b1, 32'h8000_0000, 4'h8, 32'h7800_0000, 1'b1}) begin
            failures++;
            $display("FAIL sb_beat got=%b addr=%h mask=%h wdata=%h wen=%b expected 1 80000000 8 78000000 1",
                     got, a, m, wd, we);
        end
        take_rsp(rd, err, got);
        checks++;
        if ({got, err, rd} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL sb_rsp got=%b err=%b rdata=%h expected 1 0 00000000", got, err, rd);
        end
    endtask

    task automatic test_load_half();
        logic [31:0] a, wd, rd;
        logic [3:0]  m;
        logic        we, got, err;
        logic [2:0]  ops [2]  = '{3'b001, 3'b101};
        logic [31:0] exps [2] = '{32'hFFFF_FFEE, 32'h0000_FFEE};
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, ops[k], 32'h8000_0002, 32'h0);
            serve_beat(32'hFFEE_1234, a, m, wd, we, got);
            checks++;
            if ({got, a, m, we} !== {1'b1, 32'h8000_0000, 4'hC, 1'b0}) begin
                failures++;
                $display("FAIL lh_beat op=%b got=%b addr=%h mask=%h wen=%b expected 1 80000000 c 0",
                         ops[k], got, a, m, we);
            end
            take_rsp(rd, err, got);
            checks++;
            if ({got, err, rd} !== {1'b1, 1'b0, exps[k]}) begin
                failures++;
                $display("FAIL lh_rsp op=%b got=%b err=%b rdata=%h expected 1 0 %h",
                         ops[k], got, err, rd, exps[k]);
            end
        end
    endtask

    task automatic test_split_load();
        logic [31:0] a, wd, rd;
        logic [3:0]  m;
        logic        we, got, err;
        issue(1'b0, 3'b010, 32'h8000_0003, 32'h0);
        serve_beat(32'hAABB_CCDD, a, m, wd, we, got);
        checks++;
        if ({got, a, m, we} !== {1'b1, 32'h8000_0000, 4'h8, 1'b0}) begin
            failures++;
            $display("FAIL lw_split_beat0 got=%b addr=%h mask=%h wen=%b expected 1 80000000 8 0",
                     got, a, m, we);
        end
        serve_beat(32'h1122_3344, a, m, wd, we, got);
        checks++;
        if ({got, a, m, we} !== {1'b1, 32'h8000_0004, 4'h7, 1'b0}) begin
            failures++;
            $display("FAIL lw_split_beat1 got=%b addr=%h mask=%h wen=%b expected 1 80000004 7 0",
                     got, a, m, we);
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL lw_split_latency rsp_valid=%b expected 1 at cycle 5", rsp_valid);
        end
        take_rsp(rd, err, got);
        checks++;
        if ({got, err, rd} !== {1'b1, 1'b0, 32'h2233_44AA}) begin
            failures++;
            $display("FAIL lw_split_rsp got=%b err=%b rdata=%h expected 1 0 223344aa", got, err, rd);
        end
    endtask

    task automatic test_split_store();
        logic [31:0] a, wd, rd;
        logic [3:0]  m;
        logic        we, got, err;
        issue(1'b1, 3'b001, 32'h8000_0003, 32'h0000_ABCD);
        serve_beat(32'h0, a, m, wd, we, got);
        checks++;
        if ({got, a, m, wd, we} !== {1'b1, 32'h8000_0000, 4'h8, 32'hCD00_0000, 1'b1}) begin
            failures++;
            $display("FAIL sh_split_beat0 got=%b addr=%h mask=%h wdata=%h wen=%b expected 1 80000000 8 cd000000 1",
                     got, a, m, wd, we);
        end
        serve_beat(32'h0, a, m, wd, we, got);
        checks++;
        if ({got, a, m, wd, we} !== {1'b1, 32'h8000_0004, 4'h1, 32'h0000_00AB, 1'b1}) begin
            failures++;
            $display("FAIL sh_split_beat1 got=%b addr=%h mask=%h wdata=%h wen=%b expected 1 80000004 1 000000ab 1",
                     got, a, m, wd, we);
        end
        take_rsp(rd, err, got);
        checks++;
        if ({got, err, rd} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL sh_split_rsp got=%b err=%b rdata=%h expected 1 0 00000000", got, err, rd);
        end
    endtask

    task automatic test_no_split();
        logic saw_beat;
        req_valid_ns = 1'b1;
        req_wen      = 1'b0;
        req_op       = 3'b010;
        req_addr     = 32'h8000_0003;
        req_wdata    = 32'h0;
        @(negedge clk);
        req_valid_ns = 1'b0;
        saw_beat     = mem_req_valid_ns;
        checks++;
        if ({rsp_valid_ns, rsp_err_ns, rsp_rdata_ns} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL nosplit_err rv=%b err=%b rdata=%h expected 1 1 00000000 at cycle 1",
                     rsp_valid_ns, rsp_err_ns, rsp_rdata_ns);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_beat |= mem_req_valid_ns;
        end
        rsp_ready_ns = 1'b1;
        @(negedge clk);
        rsp_ready_ns = 1'b0;
        saw_beat |= mem_req_valid_ns;
        checks++;
        if (saw_beat !== 1'b0) begin
            failures++;
            $display("FAIL nosplit_no_beat mem_req_valid seen=%b expected 0", saw_beat);
        end
        checks++;
        if ({req_ready_ns, rsp_valid_ns} !== 2'b10) begin
            failures++;
            $display("FAIL nosplit_idle rdy=%b rv=%b expected 1 0", req_ready_ns, rsp_valid_ns);
        end
    endtask

    task automatic test_illegal_op();
        logic [31:0] rd;
        logic        err, got;
        logic        ops_wen [2] = '{1'b0, 1'b1};
        logic [2:0]  ops     [2] = '{3'b011, 3'b100};
        for (int k = 0; k < 2; k++) begin
            issue(ops_wen[k], ops[k], 32'h8000_0000, 32'h5555_5555);
            checks++;
            if ({rsp_valid, rsp_err, mem_req_valid} !== 3'b110) begin
                failures++;
                $display("FAIL illegal_cycle1 wen=%b op=%b rv=%b err=%b mv=%b expected 1 1 0",
                         ops_wen[k], ops[k], rsp_valid, rsp_err, mem_req_valid);
            end
            take_rsp(rd, err, got);
            checks++;
            if ({got, err, rd} !== {1'b1, 1'b1, 32'h0}) begin
                failures++;
                $display("FAIL illegal_rsp op=%b got=%b err=%b rdata=%h expected 1 1 00000000",
                         ops[k], got, err, rd);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, wd, rd;
        logic [3:0]  m;
        logic        we, got, err;
        issue(1'b0, 3'b010, 32'h8000_0008, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req_valid, mem_addr, mem_wmask, mem_wen} !== {1'b1, 32'h8000_0008, 4'hF, 1'b0}) begin
                failures++;
                $display("FAIL bp_bus_hold cycle=%0d mv=%b addr=%h mask=%h wen=%b expected 1 80000008 f 0",
                         i, mem_req_valid, mem_addr, mem_wmask, mem_wen);
            end
            @(negedge clk);
        end
        serve_beat(32'h5A5A_A5A5, a, m, wd, we, got);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, 1'b0, 32'h5A5A_A5A5, 1'b0}) begin
                failures++;
                $display("FAIL bp_rsp_hold cycle=%0d rv=%b err=%b rdata=%h rdy=%b expected 1 0 5a5aa5a5 0",
                         i, rsp_valid, rsp_err, rsp_rdata, req_ready);
            end
            @(negedge clk);
        end
        take_rsp(rd, err, got);
        checks++;
        if ({got, err, rd, req_ready} !== {1'b1, 1'b0, 32'h5A5A_A5A5, 1'b1}) begin
            failures++;
            $display("FAIL bp_rsp got=%b err=%b rdata=%h rdy=%b expected 1 0 5a5aa5a5 1",
                     got, err, rd, req_ready);
        end
    endtask

    task automatic test_reset_midway();
        issue(1'b1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        // now waiting for beat 0 response
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_req_valid, mem_wen} !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_ctrl {rdy,rv,err,mv,wen}=%b expected 10000",
                     {req_ready, rsp_valid, rsp_err, mem_req_valid, mem_wen});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_wdata, mem_wmask} !== 100'd0) begin
            failures++;
            $display("FAIL midreset_data rdata=%h addr=%h wdata=%h mask=%h expected all 0",
                     rsp_rdata, mem_addr, mem_wdata, mem_wmask);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // A stray bus response in IDLE must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, mem_req_valid} !== 3'b100) begin
            failures++;
            $display("FAIL stray_rsp rdy=%b rv=%b mv=%b expected 1 0 0",
                     req_ready, rsp_valid, mem_req_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, wd, rd;
        logic [3:0]  m;
        logic        we, got, err;
        logic [2:0]  ops  [2] = '{3'b100, 3'b000};
        logic [31:0] exps [2] = '{32'h0000_0080, 32'hFFFF_FF80};
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready k=%0d req_ready=%b expected 1", k, req_ready);
            end
            issue(1'b0, ops[k], 32'h8000_0001, 32'h0);
            serve_beat(32'h0000_8000, a, m, wd, we, got);
            checks++;
            if ({got, a, m} !== {1'b1, 32'h8000_0000, 4'h2}) begin
                failures++;
                $display("FAIL b2b_beat op=%b got=%b addr=%h mask=%h expected 1 80000000 2",
                         ops[k], got, a, m);
            end
            take_rsp(rd, err, got);
            checks++;
            if ({got, err, rd} !== {1'b1, 1'b0, exps[k]}) begin
                failures++;
                $display("FAIL b2b_rsp op=%b got=%b err=%b rdata=%h expected 1 0 %h",
                         ops[k], got, err, rd, exps[k]);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_valid_ns  = 1'b0;
        req_wen       = 1'b0;
        req_op        = 3'b000;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        rsp_ready     = 1'b0;
        rsp_ready_ns  = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();

        test_store_word();
        test_store_byte();
        test_load_half();
        test_split_load();
        test_split_store();
        test_no_split();
        test_illegal_op();
        test_backpressure();
        test_reset_midway();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25050147_lsu.md
# ysyx_25050147_lsu

Parametrised load/store unit between the execute stage and the data-memory bus of the NPC core. It performs byte-lane alignment, write-mask generation and load sign/zero extension for XLEN of 32 or 64. Unlike the purely combinational store/load aligner, it owns a valid/ready handshake on both sides and sequences bus beats. It can split a word-boundary-crossing misaligned access into two aligned beats, or reject it with an error.

## Interface
Parameters:
- XLEN, 32, data width; 32 or 64. NB = XLEN/8 bytes per beat.
- AW, 32, address width.
- SPLIT_MISALIGNED, 1, 1: split crossing accesses into two beats; 0: return error.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request from EXU.
- req_ready  out  1  high exactly when state is IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_op  in  3  RISC-V funct3.
- req_addr  in  AW  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal op or disallowed misaligned access.
- mem_req_valid  out  1  bus beat request.
- mem_req_ready  in  1  bus accepts beat.
- mem_addr  out  AW  beat address, aligned to NB.
- mem_wen  out  1  beat is a write.
- mem_wdata  out  XLEN  lane-shifted write data.
- mem_wmask  out  NB  byte-enable mask.
- mem_rsp_valid  in  1  read data / write ack. Always accepted.
- mem_rdata  in  XLEN  read data.

## Operation
- Size from op[1:0]: 00 byte, 01 half, 10 word, 11 double.
- Loads: op[2] = 1 means zero-extend.
- Legal loads: 000, 001, 010, 100, 101. With XLEN = 64, 011 and 110 are also legal.
- Legal stores: 000, 001, 010. With XLEN = 64, 011 is also legal.
- Every other op gives rsp_err = 1 and no bus beat.
- off = addr mod NB. base = addr with the low bits cleared.
- Size mask: m = (1 << size) - 1, one bit per byte.
- Crossing condition: off + size > NB.
- Non-crossing access: one beat at base. mem_wmask = m << off (truncated to NB). mem_wdata = wdata << 8·off.
- Crossing access, SPLIT = 1:
  - Beat 0 at base: mask = (m << off) truncated to NB; wdata = wdata << 8·off.
  - Beat 1 at base + NB: mask = m >> (NB − off); wdata = wdata >> 8·(NB − off).
  - Load result: (d0 >> 8·off) | (d1 << 8·(NB − off)), then extended.
- Crossing access, SPLIT = 0: error, no bus beat.
- Load result: take the low size bytes of the shifted data, then sign- or zero-extend to XLEN.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE → REQ0 on req_valid, for a legal request.
  - IDLE → RESP for an error; rsp_err is latched.
  - REQ0 → WAIT0 on mem_req_ready.
  - WAIT0 → REQ1 on mem_rsp_valid if the access splits; otherwise WAIT0 → RESP.
  - REQ1 → WAIT1 on mem_req_ready.
  - WAIT1 → RESP on mem_rsp_valid.
  - RESP → IDLE on rsp_ready.
- The request is captured into registers at acceptance. Later changes on req_* have no effect.
- Beat-0 read data is held in a register until beat 1 returns.

## Timing
- Reset values:
  - State IDLE, so req_ready = 1.
  - rsp_valid, rsp_err, mem_req_valid and mem_wen are 0.
  - rsp_rdata, mem_addr, mem_wdata and mem_wmask are 0.
- Assertion of rst_n mid-transaction returns the FSM to IDLE immediately. Any pending bus beat is abandoned.
- mem_req_valid and mem_addr/wdata/wmask/wen are register-driven and stable while mem_req_valid is high and mem_req_ready is low.
- mem_rsp_valid is ignored outside the WAIT states.
- Aligned access with zero-wait bus:
  - Accept at cycle 0.
  - mem_req_valid at cycle 1.
  - mem_rsp_valid at cycle 2 at the earliest.
  - rsp_valid at cycle 3.
- A split access adds 2 cycles.
- An error gives rsp_valid at cycle 1.
- rsp_valid, rsp_rdata and rsp_err are held until rsp_ready. A new request is accepted the cycle after the RESP handshake.

## Structure
- Package ysyx_25050147_lsu_pkg contains:
  - The state enum.
  - funct3 localparams: LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD.
  - The size-decode function.
- Sub-module ysyx_25050147_lsu_align is combinational. It generates masks and shifted write data for both beats, and does load merge plus extension. It is parametrised by XLEN.

## Test plan
All scenarios use XLEN = 32 unless stated otherwise.
- SW at 0x80000004, data 0xDEADBEEF -> single beat: addr 0x80000004, mask 0xF, wdata 0xDEADBEEF. rsp_err 0.
- SB at 0x80000003, data 0x12345678 -> mask 0x8, wdata 0x78000000.
- LH / LHU at 0x80000002, mem_rdata 0xFFEE1234 -> rsp_rdata 0xFFFFFFEE / 0x0000FFEE.
- LW at 0x80000003, SPLIT = 1:
  - Beat 0 at 0x80000000, mask 0x8, read 0xAABBCCDD.
  - Beat 1 at 0x80000004, mask 0x7, read 0x11223344.
  - Result 0x223344AA.
  - With SPLIT = 0: rsp_err 1, and mem_req_valid never rises.
- SH at 0x80000003, data 0xABCD -> beat 0: mask 0x8, wdata 0xCD000000. Beat 1: mask 0x1, wdata 0x000000AB.
- Backpressure and reset:
  - mem_req_ready held low 3 cycles, and rsp_ready low 2 cycles -> bus and rsp outputs stay stable.
  - rst_n pulsed during WAIT0 -> IDLE, all outputs at reset values.
  - Op 011 with XLEN = 32 -> error at cycle 1.
